apb_master_gen: RTL and testbench
=================================

APB_MASTER_GEN -- requirements
Module: apb_master_gen

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of APB slave select lines (1..16).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1000_0000, start of decoded window, aligned to 2^SLOT_SHIFT.
REQ-003 SHALL have parameter SLOT_SHIFT, default 12, log2 of per-slave region size (4 KB).
REQ-004 SHALL have parameter TIMEOUT, default 16, ACCESS cycles without PREADY before abort; 0 disables timeout.
REQ-005 SHALL have port PCLK, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port PRESETn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports transfer (input, 1, request strobe), write (input, 1, 1=write), addr (input, 32, byte address) and wdata (input, 32, write data).
REQ-008 SHALL have ports ready (output, 1, completion pulse), error (output, 1, qualifies ready) and rdata (output, 32, read data).
REQ-009 SHALL have ports PADDR (output, 32), PWRITE (output, 1), PENABLE (output, 1), PWDATA (output, 32) and PSEL (output, NUM_SLAVES, one-hot select).
REQ-010 SHALL have ports PRDATA (input, 32*NUM_SLAVES; slave i in bits [32i+31:32i]), PREADY (input, NUM_SLAVES) and PSLVERR (input, NUM_SLAVES).

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-012 SHALL sample transfer only in IDLE; transfer in SETUP/ACCESS SHALL be ignored (no queueing).
REQ-013 SHALL latch addr, write and wdata into PADDR, PWRITE and PWDATA at the edge where transfer is accepted; these SHALL hold stable until the transfer ends.
REQ-014 SHALL decode slave index = (addr - BASE_ADDR) >> SLOT_SHIFT; hit iff BASE_ADDR <= addr < BASE_ADDR + (NUM_SLAVES << SLOT_SHIFT).
REQ-015 On hit, IDLE->SETUP: PSEL[index]=1, PENABLE=0 for exactly one cycle; then SETUP->ACCESS unconditionally with PENABLE=1.
REQ-016 On miss, SHALL stay in IDLE, assert no PSEL bit, and pulse ready=1, error=1, rdata=0 in the following cycle.
REQ-017 In ACCESS, at each edge where PREADY[index]=1, SHALL complete: ACCESS->IDLE, PSEL=0, PENABLE=0; ready=1 for exactly one cycle after that edge.
REQ-018 On completion, error SHALL equal PSLVERR[index] sampled at the completing edge.
REQ-019 On a successful read, rdata SHALL capture PRDATA slice [index]; on a read with PSLVERR, rdata SHALL be 0; on a write, rdata SHALL be unchanged.
REQ-020 PREADY/PSLVERR/PRDATA of unselected slaves SHALL be ignored.
REQ-021 Wait counter SHALL clear on entering ACCESS and increment at each ACCESS edge with PREADY[index]=0.
REQ-022 When TIMEOUT != 0 and the counter reaches TIMEOUT, SHALL abort: ACCESS->IDLE, PSEL=0, PENABLE=0, then ready=1, error=1, rdata=0 for one cycle.
REQ-023 PREADY arriving on the same edge the counter reaches TIMEOUT SHALL count as completion, not timeout.
REQ-024 Minimum latency: transfer accepted at edge N, zero-wait slave -> ready high during cycle N+2..N+3.
REQ-025 ready and error SHALL be registered; error=0 whenever ready=0.
REQ-026 At most one PSEL bit SHALL be high at any time; PENABLE=1 only with a PSEL bit high.
REQ-027 A transfer SHALL be accepted in the same cycle ready is high (FSM already IDLE), giving back-to-back operation.

Reset
REQ-028 PRESETn low SHALL immediately force state IDLE, wait counter 0, and PADDR, PWDATA, PWRITE, PENABLE, PSEL, ready, error, rdata to 0, regardless of clock.
REQ-029 Reset mid-transfer SHALL abort without a ready pulse; first transfer after PRESETn rises SHALL be accepted normally.

Verification
REQ-030 Write 32'h1000_0004 <- 32'd2, slave0 zero-wait -> PSEL=4'b0001 one SETUP cycle, PENABLE next cycle, ready/error=1/0 at N+2.
REQ-031 Write then read 32'h1000_2008, slave2 returning 32'hCAFE_0003 after 3 wait cycles -> PSEL=4'b0100, ready at N+5, rdata=32'hCAFE_0003.
REQ-032 Read 32'h1000_4000 (miss, NUM_SLAVES=4) -> no PSEL activity, ready=1, error=1, rdata=0 next cycle.
REQ-033 Slave1 holds PREADY=0 -> abort after 16 ACCESS cycles, ready=1, error=1; PREADY rising on 16th edge -> normal completion.
REQ-034 Slave3 PREADY=1, PSLVERR=1 on read -> ready=1, error=1, rdata=0; transfer pulse during ACCESS ignored.
REQ-035 Assert PRESETn=0 during ACCESS -> all outputs 0 asynchronously, no ready; after release, write to 32'h1000_0000 completes normally.

Source files
------------

// File: rtl/apb_master_gen_if.sv
// ----------------------------------------------------------------------------
// apb_master_gen_if
// Purpose : APB bus bundle between the apb_master_gen bridge and its slaves.
//           The master modport drives the request phase and reads back the
//           per-slave response vectors; the slave modport is the mirror view.
// Signals : PADDR   [31:0]            byte address of the current transfer
//           PWRITE                    1 = write, 0 = read
//           PENABLE                   high during the ACCESS phase
//           PWDATA  [31:0]            write data
//           PSEL    [NUM_SLAVES-1:0]  one-hot slave select
//           PRDATA  [32*NUM_SLAVES-1:0] read data, slave i in [32i+31:32i]
//           PREADY  [NUM_SLAVES-1:0]  per-slave transfer-done
//           PSLVERR [NUM_SLAVES-1:0]  per-slave error, valid with PREADY
// ----------------------------------------------------------------------------
interface apb_master_gen_if #(
    parameter int NUM_SLAVES = 4
) ();
    logic [31:0]              PADDR;
    logic                     PWRITE;
    logic                     PENABLE;
    logic [31:0]              PWDATA;
    logic [NUM_SLAVES-1:0]    PSEL;
    logic [32*NUM_SLAVES-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]    PREADY;
    logic [NUM_SLAVES-1:0]    PSLVERR;

    modport master (
        output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_gen.sv
// ----------------------------------------------------------------------------
// apb_master_gen
// Purpose : Single-outstanding APB master. A one-cycle 'transfer' strobe in
//           IDLE launches a transfer to the slave whose 2^SLOT_SHIFT window
//           contains 'addr'. Addresses outside the decoded window are answered
//           locally with an error. A slave that never raises PREADY is
//           abandoned after TIMEOUT ACCESS cycles (0 = wait forever).
// Ports   : PCLK, PRESETn          clock, asynchronous active-low reset
//           transfer, write        request strobe and direction (1 = write)
//           addr, wdata [31:0]     request address and write data
//           ready                  one-cycle completion pulse
//           error                  qualifies ready (miss, timeout, PSLVERR)
//           rdata [31:0]           read data of the last completed read
//           apb                    APB bus, master modport
// ----------------------------------------------------------------------------
module apb_master_gen #(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          SLOT_SHIFT = 12,
    parameter int          TIMEOUT    = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             transfer,
    input  logic             write,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             ready,
    output logic             error,
    output logic [31:0]      rdata,
    apb_master_gen_if.master apb
);

    localparam int          IDXW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int          CNTW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [32:0] WINDOW = 33'(NUM_SLAVES) << SLOT_SHIFT;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDXW-1:0] sel_idx;
    logic [CNTW-1:0] wait_cnt;
    logic [31:0]     offset;
    logic            hit;
    logic [IDXW-1:0] req_idx;
    logic            accept;
    logic            done_ok;
    logic            done_abort;
    logic            timeout_hit;
    logic            sel_ready;
    logic            sel_err;
    logic [31:0]     sel_rdata;

    // Address decode. The window test works on the offset from BASE_ADDR so a
    // window ending exactly at 2^32 does not wrap; an address below the base
    // gives a huge offset and therefore misses as well.
    assign offset  = addr - BASE_ADDR;
    assign hit     = (addr >= BASE_ADDR) && ({1'b0, offset} < WINDOW);
    assign req_idx = IDXW'(offset >> SLOT_SHIFT);

    // Only the selected slave's response lanes are looked at; everything the
    // other slaves drive is ignored.
    assign sel_ready = apb.PREADY[sel_idx];
    assign sel_err   = apb.PSLVERR[sel_idx];
    assign sel_rdata = apb.PRDATA[{sel_idx, 5'd0} +: 32];

    // A PREADY on the same edge wins over the timeout because done_ok is
    // evaluated first in the next-state logic.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNTW'(TIMEOUT - 1));

    // State register; reset drops straight back to IDLE without any response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the one-cycle event strobes that steer the
    // datapath. A miss is accepted but never leaves IDLE, which is what lets
    // the local error answer come back one cycle after the request.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    accept = 1'b1;
                    if (hit) begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    done_ok = 1'b1;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    done_abort = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus-side registers. Address, direction and data are captured at the
    // accepting edge and then left alone until the next accept, so they stay
    // stable for the whole transfer whatever the requester does meanwhile.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            apb.PADDR   <= '0;
            apb.PWRITE  <= 1'b0;
            apb.PWDATA  <= '0;
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            sel_idx     <= '0;
        end else begin
            if (accept) begin
                apb.PADDR  <= addr;
                apb.PWRITE <= write;
                apb.PWDATA <= wdata;
                if (hit) begin
                    apb.PSEL <= NUM_SLAVES'(1) << req_idx;
                    sel_idx  <= req_idx;
                end
            end
            if (state_q == SETUP) begin
                apb.PENABLE <= 1'b1;
            end
            if (done_ok || done_abort) begin
                apb.PSEL    <= '0;
                apb.PENABLE <= 1'b0;
            end
        end
    end

    // ACCESS-phase wait counter: restarted when SETUP hands over to ACCESS,
    // bumped on every ACCESS edge the selected slave is still busy.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if ((state_q == SETUP) || done_abort) begin
            wait_cnt <= '0;
        end else if ((state_q == ACCESS) && !sel_ready) begin
            wait_cnt <= wait_cnt + CNTW'(1);
        end
    end

    // Requester-side response. ready/error default low every cycle so each
    // event yields exactly one pulse. Misses and timeouts clear rdata, a
    // slave error on a read clears it, and writes leave it untouched.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ready <= 1'b0;
            error <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            if (accept && !hit) begin
                ready <= 1'b1;
                error <= 1'b1;
                rdata <= '0;
            end
            if (done_ok) begin
                ready <= 1'b1;
                error <= sel_err;
                if (!apb.PWRITE) begin
                    rdata <= sel_err ? 32'd0 : sel_rdata;
                end
            end
            if (done_abort) begin
                ready <= 1'b1;
                error <= 1'b1;
                rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_gen.sv
// ----------------------------------------------------------------------------
// tb_apb_master_gen
// Purpose : Self-checking bench for apb_master_gen. A small slave model answers
//           the selected slave after a configurable number of wait cycles and
//           drives random noise on every unselected slave lane. Expected
//           latency, error and rdata come from a transaction-level model of
//           the address map, wait/timeout rule and rdata update rule.
// ----------------------------------------------------------------------------
module tb_apb_master_gen;

    localparam int          NS    = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          SHIFT = 12;
    localparam int          TMO   = 16;

    logic        PCLK     = 1'b0;
    logic        PRESETn  = 1'b1;
    logic        transfer = 1'b0;
    logic        write    = 1'b0;
    logic [31:0] addr     = '0;
    logic [31:0] wdata    = '0;
    logic        ready;
    logic        error;
    logic [31:0] rdata;

    apb_master_gen_if #(.NUM_SLAVES(NS)) bus ();

    apb_master_gen #(
        .NUM_SLAVES(NS),
        .BASE_ADDR (BASE),
        .SLOT_SHIFT(SHIFT),
        .TIMEOUT   (TMO)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .transfer(transfer),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .error   (error),
        .rdata   (rdata),
        .apb     (bus)
    );

    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;

    int          slave_wait [NS];
    logic        slave_err  [NS];
    logic [31:0] slave_data [NS];
    int          access_cnt = 0;
    logic [NS-1:0]    noise_rdy  = '0;
    logic [NS-1:0]    noise_err  = '0;
    logic [32*NS-1:0] noise_data = '0;
    logic [31:0]      model_rdata = '0;

    // Counts completed ACCESS cycles of the current transfer so a slave can
    // answer after slave_wait cycles; a negative wait means never answer.
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            access_cnt <= 0;
        end else if (bus.PENABLE) begin
            access_cnt <= access_cnt + 1;
        end else begin
            access_cnt <= 0;
        end
    end

    // Fresh garbage for every lane each cycle; only unselected lanes keep it.
    always @(negedge PCLK) begin
        noise_rdy <= NS'($urandom);
        noise_err <= NS'($urandom);
        for (int i = 0; i < NS; i++) begin
            noise_data[32*i +: 32] <= $urandom;
        end
    end

    // Slave responder model.
    always_comb begin
        bus.PREADY  = noise_rdy;
        bus.PSLVERR = noise_err;
        bus.PRDATA  = noise_data;
        for (int i = 0; i < NS; i++) begin
            if (bus.PSEL[i]) begin
                bus.PREADY[i]          = bus.PENABLE && (slave_wait[i] >= 0) && (access_cnt == slave_wait[i]);
                bus.PSLVERR[i]         = slave_err[i];
                bus.PRDATA[32*i +: 32] = slave_data[i];
            end
        end
    end

    // Address map of the reference model.
    function automatic logic is_hit(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < longint'(NS) * (longint'(1) << SHIFT));
    endfunction

    function automatic int slot_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / (longint'(1) << SHIFT));
    endfunction

    // Transaction-level expectation: cycles from the accepting edge to the
    // ready pulse, the error flag, the resulting rdata and the PSEL pattern.
    function automatic void predict(input logic [31:0] a, input logic wr,
                                    output int lat, output logic err,
                                    output logic [31:0] rd, output logic [NS-1:0] ps);
        int idx;
        int w;
        ps = '0;
        if (!is_hit(a)) begin
            lat = 0;
            err = 1'b1;
            rd  = 32'd0;
        end else begin
            idx     = slot_of(a);
            ps[idx] = 1'b1;
            w       = slave_wait[idx];
            if ((w < 0) || (w >= TMO)) begin
                lat = TMO + 1;
                err = 1'b1;
                rd  = 32'd0;
            end else begin
                lat = 2 + w;
                err = slave_err[idx];
                rd  = wr ? model_rdata : (slave_err[idx] ? 32'd0 : slave_data[idx]);
            end
        end
        model_rdata = rd;
    endfunction

    // Drives one request and observes the bus until ready (bounded). With
    // glitch set, transfer is held high with another address while busy.
    task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                                 input logic glitch, output int lat,
                                 output logic [NS-1:0] psel_setup, output logic pen_setup,
                                 output logic pen_access, output logic [NS-1:0] psel_any,
                                 output int viol, output logic err_o, output logic [31:0] rd_o);
        addr     = a;
        write    = wr;
        wdata    = wd;
        transfer = 1'b1;
        @(posedge PCLK);
        #1;
        transfer   = glitch;
        addr       = glitch ? BASE : $urandom;
        write      = 1'($urandom);
        wdata      = $urandom;
        lat        = -1;
        psel_setup = bus.PSEL;
        pen_setup  = bus.PENABLE;
        pen_access = 1'b0;
        psel_any   = '0;
        viol       = 0;
        err_o      = 1'b0;
        rd_o       = '0;
        for (int k = 0; k <= TMO + 4; k++) begin
            if (k > 0) begin
                @(posedge PCLK);
                #1;
            end
            if (k == 1) pen_access = bus.PENABLE;
            psel_any |= bus.PSEL;
            if ($countones(bus.PSEL) > 1) viol++;
            if (bus.PENABLE && (bus.PSEL == '0)) viol++;
            if (error && !ready) viol++;
            if ((bus.PSEL != '0) && ((bus.PADDR !== a) || (bus.PWRITE !== wr) || (bus.PWDATA !== wd))) viol++;
            if (ready) begin
                lat   = k;
                err_o = error;
                rd_o  = rdata;
                break;
            end
        end
        transfer = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b1;
        #2 PRESETn = 1'b0;
        #2;
        checks++; if ({ready, error, bus.PWRITE, bus.PENABLE} !== 4'b0) begin failures++; $display("[TB] FAIL reset_flags: got %b expected 0000", {ready, error, bus.PWRITE, bus.PENABLE}); end
        checks++; if (bus.PSEL !== '0) begin failures++; $display("[TB] FAIL reset_psel: got %b expected 0", bus.PSEL); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if ({bus.PADDR, bus.PWDATA} !== 64'd0) begin failures++; $display("[TB] FAIL reset_addr_data: got %h expected 0", {bus.PADDR, bus.PWDATA}); end
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        checks++; if ({ready, bus.PSEL, bus.PENABLE} !== '0) begin failures++; $display("[TB] FAIL idle_after_reset: got %b expected 0", {ready, bus.PSEL, bus.PENABLE}); end
    endtask

    task automatic test_write_basic();
        int lat, e_lat, viol;
        logic [NS-1:0] ps, e_ps, pany;
        logic pen0, pen1, er, e_er;
        logic [31:0] rd, e_rd;
        slave_wait[0] = 0; slave_err[0] = 1'b0; slave_data[0] = 32'h5555_0000;
        predict(32'h1000_0004, 1'b1, e_lat, e_er, e_rd, e_ps);
        applyStimulus(32'h1000_0004, 1'b1, 32'd2, 1'b0, lat, ps, pen0, pen1, pany, viol, er, rd);
        checks++; if (ps !== e_ps) begin failures++; $display("[TB] FAIL wr_psel: got %b expected %b", ps, e_ps); end
        checks++; if ({pen0, pen1} !== 2'b01) begin failures++; $display("[TB] FAIL wr_penable_phases: got %b expected 01", {pen0, pen1}); end
        checks++; if (lat !== e_lat) begin failures++; $display("[TB] FAIL wr_latency: got %0d expected %0d", lat, e_lat); end
        checks++; if ({er, rd} !== {e_er, e_rd}) begin failures++; $display("[TB] FAIL wr_resp: got %b/%h expected %b/%h", er, rd, e_er, e_rd); end
        checks++; if (viol !== 0) begin failures++; $display("[TB] FAIL wr_protocol: got %0d violations expected 0", viol); end
        @(posedge PCLK);
        #1;
        checks++; if ({ready, error, bus.PSEL} !== '0) begin failures++; $display("[TB] FAIL wr_single_pulse: got %b expected 0", {ready, error, bus.PSEL}); end
    endtask

    task automatic test_wait_read();
        int lat, e_lat, viol;
        logic [NS-1:0] ps, e_ps, pany;
        logic pen0, pen1, er, e_er;
        logic [31:0] rd, e_rd;
        slave_wait[2] = 3; slave_err[2] = 1'b0; slave_data[2] = 32'hCAFE_0003;
        predict(32'h1000_2008, 1'b1, e_lat, e_er, e_rd, e_ps);
        applyStimulus(32'h1000_2008, 1'b1, 32'h0000_00A5, 1'b0, lat, ps, pen0, pen1, pany, viol, er, rd);
        checks++; if ({lat, ps} !== {e_lat, e_ps}) begin failures++; $display("[TB] FAIL wait_wr_lat_psel: got %0d/%b expected %0d/%b", lat, ps, e_lat, e_ps); end
        checks++; if (rd !== e_rd) begin failures++; $display("[TB] FAIL wait_wr_rdata_kept: got %h expected %h", rd, e_rd); end
        predict(32'h1000_2008, 1'b0, e_lat, e_er, e_rd, e_ps);
        applyStimulus(32'h1000_2008, 1'b0, 32'd0, 1'b0, lat, ps, pen0, pen1, pany, viol, er, rd);
        checks++; if (ps !== e_ps) begin failures++; $display("[TB] FAIL wait_rd_psel: got %b expected %b", ps, e_ps); end
        checks++; if (lat !== e_lat) begin failures++; $display("[TB] FAIL wait_rd_latency: got %0d expected %0d", lat, e_lat); end
        checks++; if ({er, rd} !== {e_er, e_rd}) begin failures++; $display("[TB] FAIL wait_rd_resp: got %b/%h expected %b/%h", er, rd, e_er, e_rd); end
        checks++; if (viol !== 0) begin failures++; $display("[TB] FAIL wait_rd_protocol: got %0d violations expected 0", viol); end
    endtask

    task automatic test_slverr();
        int lat, e_lat, viol;
        logic [NS-1:0] ps, e_ps, pany;
        logic pen0, pen1, er, e_er;
        logic [31:0] rd, e_rd;
        slave_wait[3] = 0; slave_err[3] = 1'b0; slave_data[3] = 32'h0BAD_F00D;
        predict(32'h1000_3010, 1'b0, e_lat, e_er, e_rd, e_ps);
        applyStimulus(32'h1000_3010, 1'b0, 32'd0, 1'b0, lat, ps, pen0, pen1, pany, viol, er, rd);
        checks++; if ({er, rd} !== {e_er, e_rd}) begin failures++; $display("[TB] FAIL slv_ok_read: got %b/%h expected %b/%h", er, rd, e_er, e_rd); end
        slave_wait[3] = 2; slave_err[3] = 1'b1;
        predict(32'h1000_3010, 1'b0, e_lat, e_er, e_rd, e_ps);
        applyStimulus(32'h1000_3010, 1'b0, 32'd0, 1'b1, lat, ps, pen0, pen1, pany, viol, er, rd);
        checks++; if (lat !== e_lat) begin failures++; $display("[TB] FAIL slverr_latency: got %0d expected %0d", lat, e_lat); end
        checks++; if ({er, rd} !== {e_er, e_rd}) begin failures++; $display("[TB] FAIL slverr_resp: got %b/%h expected %b/%h", er, rd, e_er, e_rd); end
        checks++; if ((viol !== 0) || (pany !== e_ps)) begin failures++; $display("[TB] FAIL slverr_ignored_req: got viol %0d psel %b expected 0/%b", viol, pany, e_ps); end
        @(posedge PCLK);
        #1;
        checks++; if ({ready, bus.PSEL} !== '0) begin failures++; $display("[TB] FAIL slverr_no_queue: got %b expected 0", {ready, bus.PSEL}); end
    endtask

    task automatic test_miss();
        int lat, e_lat, viol;
        logic [NS-1:0] ps, e_ps, pany;
        logic pen0, pen1, er, e_er;
        logic [31:0] rd, e_rd;
        logic [31:0] miss_addr [2];
        miss_addr[0] = 32'h1000_4000;
        miss_addr[1] = 32'h0FFF_FFFC;
        for (int m = 0; m < 2; m++) begin
            predict(miss_addr[m], 1'b0, e_lat, e_er, e_rd, e_ps);
            applyStimulus(miss_addr[m], 1'b0, 32'd0, 1'b0, lat, ps, pen0, pen1, pany, viol, er, rd);
            checks++; if (pany !== e_ps) begin failures++; $display("[TB] FAIL miss%0d_psel: got %b expected %b", m, pany, e_ps); end
            checks++; if (lat !== e_lat) begin failures++; $display("[TB] FAIL miss%0d_latency: got %0d expected %0d", m, lat, e_lat); end
            checks++; if ({er, rd} !== {e_er, e_rd}) begin failures++; $display("[TB] FAIL miss%0d_resp: got %b/%h expected %b/%h", m, er, rd, e_er, e_rd); end
        end
    endtask

    task automatic test_timeout();
        int lat, e_lat, viol;
        logic [NS-1:0] ps, e_ps, pany;
        logic pen0, pen1, er, e_er;
        logic [31:0] rd, e_rd;
        int waits [3];
        waits[0] = -1;
        waits[1] = TMO;
        waits[2] = TMO - 1;
        for (int t = 0; t < 3; t++) begin
            slave_wait[1] = waits[t]; slave_err[1] = 1'b0; slave_data[1] = $urandom;
            predict(32'h1000_1020, 1'b0, e_lat, e_er, e_rd, e_ps);
            applyStimulus(32'h1000_1020, 1'b0, 32'd0, 1'b0, lat, ps, pen0, pen1, pany, viol, er, rd);
            checks++; if (lat !== e_lat) begin failures++; $display("[TB] FAIL tmo%0d_latency: got %0d expected %0d", t, lat, e_lat); end
            checks++; if ({er, rd} !== {e_er, e_rd}) begin failures++; $display("[TB] FAIL tmo%0d_resp: got %b/%h expected %b/%h", t, er, rd, e_er, e_rd); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, e_lat, viol;
        logic [NS-1:0] ps, e_ps, pany;
        logic pen0, pen1, er, e_er;
        logic [31:0] rd, e_rd, a, wd;
        logic wr;
        int r;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) a = BASE + (32'(r % NS) << SHIFT) + (32'($urandom_range(0, 1023)) << 2);
            else if (r == 8) a = BASE + (32'(NS) << SHIFT) + (32'($urandom_range(0, 4095)) << 2);
            else a = BASE - (32'($urandom_range(1, 4096)) << 2);
            for (int i = 0; i < NS; i++) begin
                slave_wait[i] = ($urandom_range(0, 7) == 0) ? TMO + 2 : int'($urandom_range(0, 3));
                slave_err[i]  = ($urandom_range(0, 3) == 0);
                slave_data[i] = $urandom;
            end
            wr = 1'($urandom);
            wd = $urandom;
            predict(a, wr, e_lat, e_er, e_rd, e_ps);
            applyStimulus(a, wr, wd, 1'b0, lat, ps, pen0, pen1, pany, viol, er, rd);
            checks++; if (lat !== e_lat) begin failures++; $display("[TB] FAIL b2b%0d_latency: addr %h got %0d expected %0d", n, a, lat, e_lat); end
            checks++; if (ps !== e_ps) begin failures++; $display("[TB] FAIL b2b%0d_psel: addr %h got %b expected %b", n, a, ps, e_ps); end
            checks++; if (er !== e_er) begin failures++; $display("[TB] FAIL b2b%0d_error: addr %h got %b expected %b", n, a, er, e_er); end
            checks++; if (rd !== e_rd) begin failures++; $display("[TB] FAIL b2b%0d_rdata: addr %h got %h expected %h", n, a, rd, e_rd); end
            checks++; if (viol !== 0) begin failures++; $display("[TB] FAIL b2b%0d_protocol: got %0d violations expected 0", n, viol); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, e_lat, viol;
        logic [NS-1:0] ps, e_ps, pany;
        logic pen0, pen1, er, e_er;
        logic [31:0] rd, e_rd;
        logic ready_seen;
        slave_wait[2] = -1;
        addr = 32'h1000_2000; write = 1'b1; wdata = 32'h1234_5678; transfer = 1'b1;
        @(posedge PCLK);
        #1;
        transfer = 1'b0;
        repeat (3) begin
            @(posedge PCLK);
            #1;
        end
        checks++; if ({bus.PENABLE, bus.PSEL} !== {1'b1, 4'b0100}) begin failures++; $display("[TB] FAIL rst_mid_in_access: got %b expected 10100", {bus.PENABLE, bus.PSEL}); end
        #2 PRESETn = 1'b0;
        #1;
        checks++; if ({ready, error, bus.PWRITE, bus.PENABLE, bus.PSEL} !== '0) begin failures++; $display("[TB] FAIL rst_mid_async_flags: got %b expected 0", {ready, error, bus.PWRITE, bus.PENABLE, bus.PSEL}); end
        checks++; if ({bus.PADDR, bus.PWDATA, rdata} !== 96'd0) begin failures++; $display("[TB] FAIL rst_mid_async_data: got %h expected 0", {bus.PADDR, bus.PWDATA, rdata}); end
        ready_seen = 1'b0;
        repeat (3) begin
            @(posedge PCLK);
            #1;
            ready_seen |= ready;
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        model_rdata = '0;
        repeat (2) begin
            @(posedge PCLK);
            #1;
            ready_seen |= ready;
        end
        checks++; if (ready_seen !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_no_ready: got %b expected 0", ready_seen); end
        slave_wait[0] = 0; slave_err[0] = 1'b0;
        predict(32'h1000_0000, 1'b1, e_lat, e_er, e_rd, e_ps);
        applyStimulus(32'h1000_0000, 1'b1, 32'hA5A5_0001, 1'b0, lat, ps, pen0, pen1, pany, viol, er, rd);
        checks++; if ({lat, ps} !== {e_lat, e_ps}) begin failures++; $display("[TB] FAIL rst_after_lat_psel: got %0d/%b expected %0d/%b", lat, ps, e_lat, e_ps); end
        checks++; if ({er, rd} !== {e_er, e_rd}) begin failures++; $display("[TB] FAIL rst_after_resp: got %b/%h expected %b/%h", er, rd, e_er, e_rd); end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            slave_wait[i] = 0;
            slave_err[i]  = 1'b0;
            slave_data[i] = '0;
        end
        test_reset();
        test_write_basic();
        test_wait_read();
        test_slverr();
        test_miss();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
